instr_encoder: RTL and testbench
================================

# instr_encoder

Packs decoded instruction fields and a full-width immediate into a 32-bit RV32I/RV64I instruction word. Immediate bits are scattered per format (I/S/B/J/U), and immediates that the format cannot represent are flagged. It sits on the debug/self-test injection path, feeding synthesized instructions toward fetch. It is a 2-stage valid/ready pipeline with running counters. For every legal immediate, its output must round-trip exactly through the core's immediate generator.

## Interface
- XLEN, riscv_pkg::XLEN: immediate width (32 or 64).
- CNT_W, 32: width of enc_count.
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_opcode  in  opcode_t  major opcode, bits [6:0]
- in_rd, in_rs1, in_rs2  in  5 each  register fields
- in_funct3  in  3  funct3
- in_funct7  in  7  funct7 (R-type only)
- in_imm  in  XLEN  signed byte-offset immediate
- out_valid  out  1  instruction valid
- out_ready  in  1  consumer accepts when out_valid && out_ready
- out_instr  out  32  packed instruction
- out_err  out  1  immediate not representable (qualified by out_valid)
- clr_counts  in  1  synchronous counter clear
- enc_count  out  CNT_W  output handshakes, wraps
- err_count  out  16  output handshakes with out_err=1, saturates at 0xFFFF

## Operation
- **Formats selected by in_opcode:**
  - OP_I_TYPE, OP_LOAD, OP_JALR → I.
  - OP_STORE → S.
  - OP_BRANCH → B.
  - OP_JAL → J.
  - OP_LUI, OP_AUIPC → U.
  - Any other opcode → R: {funct7, rs2, rs1, funct3, rd, opcode}. in_imm is ignored and err is 0.
- **Packing:**
  - I: {imm[11:0], rs1, f3, rd, op}.
  - S: {imm[11:5], rs2, rs1, f3, imm[4:0], op}.
  - B: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
  - U: {imm[31:12], rd, op}.
  - Unused fields are not encoded.
- **Error (computed in stage 1):**
  - I/S: imm[XLEN-1:11] not all equal.
  - B: imm[0]=1, or imm[XLEN-1:12] not all equal.
  - J: imm[0]=1, or imm[XLEN-1:20] not all equal.
  - U: imm[11:0]≠0, or (XLEN=64) imm[63:31] not all equal.
  - On error, the word is still packed from the truncated bits shown above.
- **Stage 1** registers the inputs, the format select, and err.
- **Stage 2** registers out_instr and out_err.
- **Counters** update on the output handshake only.
- **clr_counts** zeroes both counters. It wins over a same-cycle handshake, which is then not counted.

## Timing
- Reset: all pipeline valid bits 0, out_valid=0, out_instr=0, out_err=0, enc_count=0, err_count=0. in_ready=1 once rst deasserts.
- Latency: accept in cycle N → out_valid high in cycle N+2.
- Throughput: 1 instruction/cycle while out_ready=1.
- Advance rules:
  - s2 loads when !s2_valid || out_ready.
  - s1 loads when !s1_valid || s2 loads.
  - in_ready = !s1_valid || (!s2_valid || out_ready). A combinational out_ready→in_ready path is permitted.
- out_instr and out_err are held stable while out_valid && !out_ready.
- Ordering is strictly FIFO, with no drop or duplication.
- Capacity: 2 in flight. With out_ready stuck low, at most 2 requests are accepted.
- rst asserted mid-operation: in-flight entries are discarded and out_valid falls asynchronously. No counter increments for discarded entries.
- in_valid may drop without a handshake. Field stability is only required on the accept cycle.

## Test plan
- **addi x1,x0,-1** (OP_I_TYPE, rd=1, rs1=0, f3=0, imm=-1), out_ready=1 → out_instr=0xFFF00093, out_err=0, out_valid 2 cycles after accept, enc_count=1.
- **Mixed formats back-to-back**, one per cycle:
  - beq x1,x2,+8 → 0x00208463.
  - jal x1,+2048 → 0x001000EF.
  - lui x5,0x12345000 → 0x123452B7.
  - Expected: 3 consecutive out_valid cycles, in order. Feeding each word through the immediate generator returns the original imm.
- **Errors:**
  - addi x1,x0,imm=2048 → out_instr=0x80000093, out_err=1.
  - beq imm=3 → out_err=1.
  - lui imm=0x1001 → out_err=1.
  - Expected: err_count=3.
- **Backpressure:** out_ready=0 for 5 cycles while offering 3 requests → exactly 2 accepted, in_ready=0 thereafter, out_instr stable. Release out_ready → 3 outputs in order, enc_count=3.
- **Reset mid-stream:** rst asserted with 2 in flight → out_valid=0 immediately, counters 0. After release, the next request emerges at N+2.
- **Counters:**
  - clr_counts coincident with a handshake → enc_count=0 next cycle.
  - Force err_count to 0xFFFF via 65535 erroring requests, then one more → stays 0xFFFF.

Source files
------------

// File: rtl/instr_encoder.sv
// RV32I/RV64I instruction encoder: packs decoded fields plus a full-width immediate
// into a 32-bit word through a 2-stage valid/ready pipeline, flagging unrepresentable immediates.

package riscv_pkg;
  parameter int XLEN = 32;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_I_TYPE = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_STORE  = 7'b0100011,
    OP_OP     = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111
  } opcode_t;
endpackage

// Handshake: a transfer happens on a rising edge where valid && ready are both high;
// valid never waits on ready, and payload is held stable while valid && !ready.
module instr_encoder #(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int CNT_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  riscv_pkg::opcode_t  in_opcode,
  input  logic [4:0]          in_rd,
  input  logic [4:0]          in_rs1,
  input  logic [4:0]          in_rs2,
  input  logic [2:0]          in_funct3,
  input  logic [6:0]          in_funct7,
  input  logic [XLEN-1:0]     in_imm,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_instr,
  output logic                out_err,
  input  logic                clr_counts,
  output logic [CNT_W-1:0]    enc_count,
  output logic [15:0]         err_count
);

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_J,
    FMT_U
  } fmt_e;

  // Stage 1 state
  logic        s1_valid_q;
  fmt_e        s1_fmt_q;
  logic [6:0]  s1_op_q;
  logic [4:0]  s1_rd_q;
  logic [4:0]  s1_rs1_q;
  logic [4:0]  s1_rs2_q;
  logic [2:0]  s1_f3_q;
  logic [6:0]  s1_f7_q;
  logic [31:0] s1_imm_q;
  logic        s1_err_q;

  // Stage 2 state
  logic        s2_valid_q;
  logic [31:0] out_instr_q;
  logic        out_err_q;

  logic [CNT_W-1:0] enc_count_q;
  logic [15:0]      err_count_q;

  fmt_e        fmt_d;
  logic        err_d;
  logic [31:0] instr_d;
  logic        s1_load;
  logic        s2_load;
  logic        out_hs;

  // Upper immediate slices that must be pure sign extension for each format
  logic [XLEN-12:0] hi11;
  logic [XLEN-13:0] hi12;
  logic [XLEN-21:0] hi20;
  logic [XLEN-32:0] hi31;
  logic             sx11_ok;
  logic             sx12_ok;
  logic             sx20_ok;
  logic             sx31_ok;

  assign s2_load  = !s2_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;
  assign out_hs   = s2_valid_q && out_ready;

  assign hi11    = in_imm[XLEN-1:11];
  assign hi12    = in_imm[XLEN-1:12];
  assign hi20    = in_imm[XLEN-1:20];
  assign hi31    = in_imm[XLEN-1:31];
  assign sx11_ok = (&hi11) || !(|hi11);
  assign sx12_ok = (&hi12) || !(|hi12);
  assign sx20_ok = (&hi20) || !(|hi20);
  assign sx31_ok = (&hi31) || !(|hi31);

  always_comb begin
    fmt_d = FMT_R;
    case (in_opcode)
      riscv_pkg::OP_I_TYPE,
      riscv_pkg::OP_LOAD,
      riscv_pkg::OP_JALR:   fmt_d = FMT_I;
      riscv_pkg::OP_STORE:  fmt_d = FMT_S;
      riscv_pkg::OP_BRANCH: fmt_d = FMT_B;
      riscv_pkg::OP_JAL:    fmt_d = FMT_J;
      riscv_pkg::OP_LUI,
      riscv_pkg::OP_AUIPC:  fmt_d = FMT_U;
      default:              fmt_d = FMT_R;
    endcase
  end

  always_comb begin
    err_d = 1'b0;
    case (fmt_d)
      FMT_I, FMT_S: err_d = !sx11_ok;
      FMT_B:        err_d = in_imm[0] || !sx12_ok;
      FMT_J:        err_d = in_imm[0] || !sx20_ok;
      FMT_U:        err_d = (in_imm[11:0] != 12'd0) || !sx31_ok;
      default:      err_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_fmt_q   <= FMT_R;
      s1_op_q    <= '0;
      s1_rd_q    <= '0;
      s1_rs1_q   <= '0;
      s1_rs2_q   <= '0;
      s1_f3_q    <= '0;
      s1_f7_q    <= '0;
      s1_imm_q   <= '0;
      s1_err_q   <= 1'b0;
    end else if (s1_load) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_fmt_q <= fmt_d;
        s1_op_q  <= in_opcode;
        s1_rd_q  <= in_rd;
        s1_rs1_q <= in_rs1;
        s1_rs2_q <= in_rs2;
        s1_f3_q  <= in_funct3;
        s1_f7_q  <= in_funct7;
        s1_imm_q <= in_imm[31:0];
        s1_err_q <= err_d;
      end
    end
  end

  // Erroring words are still packed from the truncated immediate bits
  always_comb begin
    instr_d = {s1_f7_q, s1_rs2_q, s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
    case (s1_fmt_q)
      FMT_I: instr_d = {s1_imm_q[11:0], s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
      FMT_S: instr_d = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_f3_q,
                        s1_imm_q[4:0], s1_op_q};
      FMT_B: instr_d = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_f3_q,
                        s1_imm_q[4:1], s1_imm_q[11], s1_op_q};
      FMT_J: instr_d = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11],
                        s1_imm_q[19:12], s1_rd_q, s1_op_q};
      FMT_U: instr_d = {s1_imm_q[31:12], s1_rd_q, s1_op_q};
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q  <= 1'b0;
      out_instr_q <= '0;
      out_err_q   <= 1'b0;
    end else if (s2_load) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_instr_q <= instr_d;
        out_err_q   <= s1_err_q;
      end
    end
  end

  // A clear on the same edge as a handshake drops that handshake from the counts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enc_count_q <= '0;
      err_count_q <= '0;
    end else if (clr_counts) begin
      enc_count_q <= '0;
      err_count_q <= '0;
    end else if (out_hs) begin
      enc_count_q <= enc_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      if (out_err_q && (err_count_q != 16'hFFFF)) begin
        err_count_q <= err_count_q + 16'd1;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_instr = out_instr_q;
  assign out_err   = out_err_q;
  assign enc_count = enc_count_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encodings, latency, errors, backpressure,
// reset mid-stream and counter clear/saturation.

module tb_instr_encoder;

  localparam int XLEN  = riscv_pkg::XLEN;
  localparam int CNT_W = 32;
  typedef logic [XLEN-1:0] imm_t;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  riscv_pkg::opcode_t in_opcode = riscv_pkg::OP_OP;
  logic [4:0]        in_rd = '0;
  logic [4:0]        in_rs1 = '0;
  logic [4:0]        in_rs2 = '0;
  logic [2:0]        in_funct3 = '0;
  logic [6:0]        in_funct7 = '0;
  imm_t              in_imm = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [31:0]       out_instr;
  logic              out_err;
  logic              clr_counts = 1'b0;
  logic [CNT_W-1:0]  enc_count;
  logic [15:0]       err_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  imm_t        imm_q[$];

  always #5 clk = ~clk;

  instr_encoder #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_funct3  (in_funct3),
    .in_funct7  (in_funct7),
    .in_imm     (in_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_err    (out_err),
    .clr_counts (clr_counts),
    .enc_count  (enc_count),
    .err_count  (err_count)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Reference immediate generator (core decode side)
  function automatic imm_t imm_gen(input logic [31:0] w);
    imm_t r;
    case (w[6:0])
      7'b0100011: r = {{(XLEN-12){w[31]}}, w[31:25], w[11:7]};
      7'b1100011: r = {{(XLEN-13){w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      7'b1101111: r = {{(XLEN-21){w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      7'b0110111, 7'b0010111: r = {{(XLEN-32){w[31]}}, w[31:12], 12'h000};
      default:    r = {{(XLEN-12){w[31]}}, w[31:20]};
    endcase
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_req(input riscv_pkg::opcode_t op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [2:0] f3, input logic [6:0] f7, input imm_t imm);
    in_opcode = op;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_funct3 = f3;
    in_funct7 = f7;
    in_imm    = imm;
  endtask

  // Returns just after the accepting rising edge with in_valid dropped.
  task automatic send_one(input riscv_pkg::opcode_t op, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [2:0] f3, input logic [6:0] f7, input imm_t imm);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    set_req(op, rd, rs1, rs2, f3, f7, imm);
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 for 20 cycles, required 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_counts = 1'b1;
    @(negedge clk);
    clr_counts = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_err !== 1'b0 ||
        enc_count !== '0 || err_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: got v=%b instr=%h err=%b enc=%0d errc=%0d, required all 0",
               out_valid, out_instr, out_err, enc_count, err_count);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_addi();
    out_ready = 1'b1;
    send_one(riscv_pkg::OP_I_TYPE, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, '1);
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL addi_latency_n1: got out_valid=%b, required 0", out_valid);
    end
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'hFFF00093 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL addi_out: got v=%b instr=%h err=%b, required v=1 instr=fff00093 err=0",
               out_valid, out_instr, out_err);
    end
    @(negedge clk); #1;
    checks++;
    if (enc_count !== 1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL addi_count: got enc=%0d v=%b, required enc=1 v=0", enc_count, out_valid);
    end
  endtask

  task automatic test_formats();
    // sub x3,x1,x2 with a junk immediate that must be ignored
    send_one(riscv_pkg::OP_OP, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, imm_t'(32'hFFFF_F001));
    @(negedge clk); @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'h402081B3 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL rtype_sub: got v=%b instr=%h err=%b, required v=1 instr=402081b3 err=0",
               out_valid, out_instr, out_err);
    end
    // sw x2,-4(x1)
    send_one(riscv_pkg::OP_STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, imm_t'(-4));
    @(negedge clk); @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'hFE20AE23 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL stype_sw: got v=%b instr=%h err=%b, required v=1 instr=fe20ae23 err=0",
               out_valid, out_instr, out_err);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words[3];
    imm_t        imms[3];
    int          first_c;
    int          got;
    words[0] = 32'h00208463; imms[0] = imm_t'(8);
    words[1] = 32'h001000EF; imms[1] = imm_t'(2048);
    words[2] = 32'h123452B7; imms[2] = imm_t'(32'h12345000);
    first_c = -1;
    got = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      case (c)
        0: set_req(riscv_pkg::OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, imms[0]);
        1: set_req(riscv_pkg::OP_JAL,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, imms[1]);
        2: set_req(riscv_pkg::OP_LUI,    5'd5, 5'd0, 5'd0, 3'd0, 7'd0, imms[2]);
        default: ;
      endcase
      in_valid = (c < 3);
      #1;
      if (c < 3) begin
        exp_q.push_back(words[c]);
        imm_q.push_back(imms[c]);
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_in_ready: cycle %0d got %b, required 1", c, in_ready);
        end
      end
      if (out_valid === 1'b1) begin
        logic [31:0] e;
        imm_t        ei;
        if (first_c < 0) first_c = c;
        e  = exp_q.pop_front();
        ei = imm_q.pop_front();
        checks++;
        if (out_instr !== e || out_err !== 1'b0 || c !== first_c + got) begin
          errors++;
          $display("FAIL b2b_word%0d: got instr=%h err=%b cycle=%0d, required instr=%h err=0 cycle=%0d",
                   got, out_instr, out_err, c, e, first_c + got);
        end
        checks++;
        if (imm_gen(out_instr) !== ei) begin
          errors++;
          $display("FAIL b2b_roundtrip%0d: got imm=%h, required %h", got, imm_gen(out_instr), ei);
        end
        got++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (got !== 3 || first_c !== 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d outputs first at %0d, required 3 first at 2", got, first_c);
    end
  endtask

  task automatic test_errors();
    out_ready = 1'b1;
    pulse_clr();
    send_one(riscv_pkg::OP_I_TYPE, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, imm_t'(2048));
    @(negedge clk); @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'h80000093 || out_err !== 1'b1) begin
      errors++;
      $display("FAIL err_addi: got v=%b instr=%h err=%b, required v=1 instr=80000093 err=1",
               out_valid, out_instr, out_err);
    end
    send_one(riscv_pkg::OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, imm_t'(3));
    @(negedge clk); @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'h00000163 || out_err !== 1'b1) begin
      errors++;
      $display("FAIL err_beq: got v=%b instr=%h err=%b, required v=1 instr=00000163 err=1",
               out_valid, out_instr, out_err);
    end
    send_one(riscv_pkg::OP_LUI, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, imm_t'(32'h1001));
    @(negedge clk); @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'h00001037 || out_err !== 1'b1) begin
      errors++;
      $display("FAIL err_lui: got v=%b instr=%h err=%b, required v=1 instr=00001037 err=1",
               out_valid, out_instr, out_err);
    end
    @(negedge clk); #1;
    checks++;
    if (err_count !== 16'd3 || enc_count !== 3) begin
      errors++;
      $display("FAIL err_count: got errc=%0d enc=%0d, required errc=3 enc=3", err_count, enc_count);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] words[3];
    logic [31:0] held;
    bit          have;
    int          accepted;
    int          got;
    words[0] = 32'h01000093;
    words[1] = 32'h02000113;
    words[2] = 32'h03000193;
    have = 1'b0;
    accepted = 0;
    got = 0;
    held = '0;
    pulse_clr();
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      set_req(riscv_pkg::OP_I_TYPE, 5'(accepted + 1), 5'd0, 5'd0, 3'd0, 7'd0,
              imm_t'(16 * (accepted + 1)));
      in_valid = 1'b1;
      #1;
      if (c >= 2) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL bp_in_ready: cycle %0d got %b, required 0", c, in_ready);
        end
      end
      if (out_valid === 1'b1) begin
        if (!have) begin
          held = out_instr;
          have = 1'b1;
        end else begin
          checks++;
          if (out_instr !== held) begin
            errors++;
            $display("FAIL bp_stable: cycle %0d got %h, required %h", c, out_instr, held);
          end
        end
      end
      if (in_ready === 1'b1) accepted++;
    end
    checks++;
    if (accepted !== 2 || held !== words[0]) begin
      errors++;
      $display("FAIL bp_accepted: got %0d held=%h, required 2 held=%h", accepted, held, words[0]);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (accepted < 3) begin
        set_req(riscv_pkg::OP_I_TYPE, 5'(accepted + 1), 5'd0, 5'd0, 3'd0, 7'd0,
                imm_t'(16 * (accepted + 1)));
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid === 1'b1) begin
        checks++;
        if (got > 2 || out_instr !== words[got % 3]) begin
          errors++;
          $display("FAIL bp_order%0d: got %h, required %h", got, out_instr, words[got % 3]);
        end
        got++;
      end
      if (in_valid && in_ready === 1'b1) accepted++;
    end
    in_valid = 1'b0;
    checks++;
    if (got !== 3 || enc_count !== 3) begin
      errors++;
      $display("FAIL bp_drain: got %0d outputs enc=%0d, required 3 outputs enc=3", got, enc_count);
    end
  endtask

  task automatic test_reset_mid();
    bit spurious;
    spurious = 1'b0;
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      set_req(riscv_pkg::OP_I_TYPE, 5'(c + 7), 5'd0, 5'd0, 3'd0, 7'd0, imm_t'(c));
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_fill: got out_valid=%b, required 1", out_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || enc_count !== '0 || err_count !== 16'h0) begin
      errors++;
      $display("FAIL rstmid_async: got v=%b enc=%0d errc=%0d, required all 0",
               out_valid, enc_count, err_count);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      if (out_valid !== 1'b0) spurious = 1'b1;
    end
    checks++;
    if (spurious) begin
      errors++;
      $display("FAIL rstmid_discard: got out_valid=1 after reset, required 0");
    end
    send_one(riscv_pkg::OP_I_TYPE, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, imm_t'(5));
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_n1: got out_valid=%b, required 0", out_valid);
    end
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'h00500293) begin
      errors++;
      $display("FAIL rstmid_n2: got v=%b instr=%h, required v=1 instr=00500293", out_valid, out_instr);
    end
    @(negedge clk); #1;
    checks++;
    if (enc_count !== 1) begin
      errors++;
      $display("FAIL rstmid_count: got enc=%0d, required 1", enc_count);
    end
  endtask

  task automatic test_counters();
    bit stalled;
    stalled = 1'b0;
    out_ready = 1'b1;
    send_one(riscv_pkg::OP_I_TYPE, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, imm_t'(2048));
    @(negedge clk);
    @(negedge clk);
    clr_counts = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL clr_setup: got out_valid=%b, required 1", out_valid);
    end
    @(negedge clk);
    clr_counts = 1'b0;
    #1;
    checks++;
    if (enc_count !== '0 || err_count !== 16'h0) begin
      errors++;
      $display("FAIL clr_wins: got enc=%0d errc=%0d, required 0 0", enc_count, err_count);
    end
    for (int i = 0; i < 65535; i++) begin
      @(negedge clk);
      set_req(riscv_pkg::OP_I_TYPE, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, imm_t'(2048));
      in_valid = 1'b1;
      #1;
      if (in_ready !== 1'b1) stalled = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (stalled || err_count !== 16'hFFFF || enc_count !== 65535) begin
      errors++;
      $display("FAIL sat_fill: got stalled=%b errc=%h enc=%0d, required stalled=0 errc=ffff enc=65535",
               stalled, err_count, enc_count);
    end
    send_one(riscv_pkg::OP_I_TYPE, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, imm_t'(2048));
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (err_count !== 16'hFFFF || enc_count !== 65536) begin
      errors++;
      $display("FAIL sat_hold: got errc=%h enc=%0d, required errc=ffff enc=65536",
               err_count, enc_count);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_formats();
    test_back_to_back();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_counters();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
